// File: rtl/dual_issue_inst_queue_if.sv
// Fetch/decode side bundle of the dual-issue instruction queue.
// master: fetch + decode (drive push/pop controls), slave: the queue itself.
interface dual_issue_inst_queue_if;
   logic        flush;
   logic        stall;
   logic        issue_i;
   logic        issue_mode_i;
   logic [31:0] inst1_i;
   logic [31:0] inst2_i;
   logic [31:0] inst1_addr_i;
   logic [31:0] inst2_addr_i;
   logic        inst1_valid_i;
   logic        inst2_valid_i;
   logic [31:0] inst1_o;
   logic [31:0] inst2_o;
   logic [31:0] inst1_addr_o;
   logic [31:0] inst2_addr_o;
   logic        inst1_valid_o;
   logic        inst2_valid_o;
   logic        buffer_full_o;
   logic        overflow_o;

   modport master (
      output flush, stall, issue_i, issue_mode_i,
      output inst1_i, inst2_i, inst1_addr_i, inst2_addr_i, inst1_valid_i, inst2_valid_i,
      input  inst1_o, inst2_o, inst1_addr_o, inst2_addr_o, inst1_valid_o, inst2_valid_o,
      input  buffer_full_o, overflow_o
   );

   modport slave (
      input  flush, stall, issue_i, issue_mode_i,
      input  inst1_i, inst2_i, inst1_addr_i, inst2_addr_i, inst1_valid_i, inst2_valid_i,
      output inst1_o, inst2_o, inst1_addr_o, inst2_addr_o, inst1_valid_o, inst2_valid_o,
      output buffer_full_o, overflow_o
   );
endinterface

// File: rtl/dual_issue_inst_queue.sv
// Circular instruction queue between fetch and dual-issue decode.
// Accepts 0-2 {pc, inst} pairs per cycle, retires 1-2, presents the two oldest.
module dual_issue_inst_queue #(
   parameter int unsigned DEPTH       = 32,
   parameter int unsigned FULL_MARGIN = 4
) (
   input logic                      clk,
   input logic                      rst,
   dual_issue_inst_queue_if.slave   bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] DepthC   = (AW+1)'(DEPTH);
   localparam logic [AW:0] FullThrC = (AW+1)'(DEPTH - FULL_MARGIN);

   logic [63:0]   mem_q [DEPTH];
   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [AW:0]   count_q, count_d;
   logic          overflow_q, overflow_d;

   logic [1:0]    npop, npush, nvalid;
   logic [AW:0]   free;
   logic          pop_en;
   logic [63:0]   wr0_data, wr1_data;
   logic [AW-1:0] head_p1, tail_p1;

   assign head_p1 = head_q + AW'(1);
   assign tail_p1 = tail_q + AW'(1);

   // Decide pop/push amounts and next pointer/count state.
   always_comb begin
      pop_en     = bus.issue_i & ~bus.stall & ~bus.flush;
      npop       = 2'd0;
      if (pop_en) begin
         if (bus.issue_mode_i && count_q >= (AW+1)'(2)) begin
            npop = 2'd2;
         end else if (count_q >= (AW+1)'(1)) begin
            npop = 2'd1;
         end
      end
      // Slots released by this cycle's pop are reusable by this cycle's push.
      free   = DepthC - count_q + (AW+1)'(npop);
      nvalid = {1'b0, bus.inst1_valid_i} + {1'b0, bus.inst2_valid_i};
      if (free >= (AW+1)'(nvalid)) begin
         npush = nvalid;
      end else begin
         npush = free[1:0];
      end
      // Compact valid inputs: inst1 ahead of inst2.
      wr0_data = bus.inst1_valid_i ? {bus.inst1_addr_i, bus.inst1_i}
                                   : {bus.inst2_addr_i, bus.inst2_i};
      wr1_data = {bus.inst2_addr_i, bus.inst2_i};

      head_d     = head_q + AW'(npop);
      tail_d     = tail_q + AW'(npush);
      count_d    = count_q + (AW+1)'(npush) - (AW+1)'(npop);
      overflow_d = overflow_q | (nvalid != npush);
      if (bus.flush) begin
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
         overflow_d = overflow_q;
      end
   end

   // Pointer, count and sticky overflow state.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Entry storage; contents past count are never observed, so no reset.
   always_ff @(posedge clk) begin
      if (!rst && !bus.flush) begin
         if (npush != 2'd0) begin
            mem_q[tail_q] <= wr0_data;
         end
         if (npush == 2'd2) begin
            mem_q[tail_p1] <= wr1_data;
         end
      end
   end

   // Head read path, zeroed when the slot is not valid.
   always_comb begin
      bus.inst1_valid_o = (count_q >= (AW+1)'(1));
      bus.inst2_valid_o = (count_q >= (AW+1)'(2));
      bus.inst1_addr_o  = bus.inst1_valid_o ? mem_q[head_q][63:32]  : 32'd0;
      bus.inst1_o       = bus.inst1_valid_o ? mem_q[head_q][31:0]   : 32'd0;
      bus.inst2_addr_o  = bus.inst2_valid_o ? mem_q[head_p1][63:32] : 32'd0;
      bus.inst2_o       = bus.inst2_valid_o ? mem_q[head_p1][31:0]  : 32'd0;
      bus.buffer_full_o = (count_q >= FullThrC);
      bus.overflow_o    = overflow_q;
   end
endmodule

// File: tb/tb_dual_issue_inst_queue.sv
// Self-checking bench for dual_issue_inst_queue: directed scenarios then random traffic,
// compared against a queue-based reference model.
module tb_dual_issue_inst_queue;
   localparam int unsigned DEPTH       = 32;
   localparam int unsigned FULL_MARGIN = 4;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_fail;

   logic [63:0] mq[$];
   logic        movf;

   dual_issue_inst_queue_if bus ();

   dual_issue_inst_queue #(
      .DEPTH       (DEPTH),
      .FULL_MARGIN (FULL_MARGIN)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      logic [63:0] e1;
      logic [63:0] e2;
      e1 = (mq.size() >= 1) ? mq[0] : 64'd0;
      e2 = (mq.size() >= 2) ? mq[1] : 64'd0;
      chk("inst1_valid", 32'(bus.inst1_valid_o), 32'(mq.size() >= 1));
      chk("inst2_valid", 32'(bus.inst2_valid_o), 32'(mq.size() >= 2));
      chk("inst1_addr", bus.inst1_addr_o, e1[63:32]);
      chk("inst1", bus.inst1_o, e1[31:0]);
      chk("inst2_addr", bus.inst2_addr_o, e2[63:32]);
      chk("inst2", bus.inst2_o, e2[31:0]);
      chk("buffer_full", 32'(bus.buffer_full_o), 32'(mq.size() >= DEPTH - FULL_MARGIN));
      chk("overflow", 32'(bus.overflow_o), 32'(movf));
   endtask

   // Apply the queue rules to the model for the inputs currently driven, clock once, compare.
   task automatic tick();
      int npop;
      int free;
      if (rst) begin
         mq.delete();
         movf = 1'b0;
      end else if (bus.flush) begin
         mq.delete();
      end else begin
         npop = 0;
         if (bus.issue_i && !bus.stall) begin
            if (bus.issue_mode_i && mq.size() >= 2) npop = 2;
            else if (mq.size() >= 1) npop = 1;
         end
         repeat (npop) void'(mq.pop_front());
         free = DEPTH - mq.size();
         if (bus.inst1_valid_i) begin
            if (free > 0) begin
               mq.push_back({bus.inst1_addr_i, bus.inst1_i});
               free--;
            end else movf = 1'b1;
         end
         if (bus.inst2_valid_i) begin
            if (free > 0) begin
               mq.push_back({bus.inst2_addr_i, bus.inst2_i});
               free--;
            end else movf = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic drive(input logic f, input logic s, input logic iss, input logic mode,
                        input logic v1, input logic v2, input logic [31:0] pc);
      bus.flush         = f;
      bus.stall         = s;
      bus.issue_i       = iss;
      bus.issue_mode_i  = mode;
      bus.inst1_valid_i = v1;
      bus.inst2_valid_i = v2;
      bus.inst1_addr_i  = pc;
      bus.inst2_addr_i  = pc + 32'd4;
      bus.inst1_i       = $urandom;
      bus.inst2_i       = $urandom;
   endtask

   task automatic idle_tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      movf   = 1'b0;
      rst    = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

      // T1: reset held two cycles, then idle
      tick();
      tick();
      rst = 1'b0;
      idle_tick();
      idle_tick();

      // T2: dual push then dual pop
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1000);
      tick();
      chk("t2_head_pc", bus.inst1_addr_o, 32'h1000);
      chk("t2_next_pc", bus.inst2_addr_o, 32'h1004);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
      tick();
      chk("t2_empty", 32'(bus.inst1_valid_o), 32'd0);

      // T3: lone inst2, then a pair, then single pop
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2000);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h2008);
      tick();
      chk("t3_head_pc", bus.inst1_addr_o, 32'h2004);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      chk("t3_pop_pc", bus.inst1_addr_o, 32'h2008);

      // T4: fill to 28, pop 10, push across the wrap, then drain
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      for (int i = 0; i < 14; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3000 + 32'(i * 8));
         tick();
      end
      chk("t4_full", 32'(bus.buffer_full_o), 32'd1);
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h4000 + 32'(i * 8));
         tick();
      end
      for (int i = 0; i < 14; i++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
         tick();
      end

      // T5: fill to 32, overflow under stall, flush keeps overflow
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h5000 + 32'(i * 8));
         tick();
      end
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h6000);
      tick();
      chk("t5_overflow", 32'(bus.overflow_o), 32'd1);
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h7000);
      tick();
      chk("t5_flush_empty", 32'(bus.inst1_valid_o), 32'd0);

      // T6: dual request with one entry, then reset with five entries
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8000);
      tick();
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h9000);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h9008);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h9010);
      tick();
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h9100);
      tick();
      rst = 1'b0;
      chk("t6_rst_ovf", 32'(bus.overflow_o), 32'd0);

      // Random traffic; issue rate varies per phase to visit full and empty
      for (int ph = 0; ph < 6; ph++) begin
         for (int i = 0; i < 100; i++) begin
            drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 5) < ph), 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom & 32'hFFFF_FFFC);
            rst = ($urandom_range(0, 249) == 0);
            tick();
         end
      end
      rst = 1'b0;
      idle_tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
